// File: rtl/dmem_pkg.sv
// Shared definitions for the block-granular data memory: bus widths, the
// cache-side byte-address split and the responder FSM state encoding.
package dmem_pkg;

   localparam int unsigned BLOCK_W         = 128;
   localparam int unsigned BLOCK_ADDR_W    = 28;
   localparam int unsigned WORD_W          = 32;
   localparam int unsigned WORDS_PER_BLOCK = BLOCK_W / WORD_W;

   // The cache strips the byte offset within a 16-byte block: block address = byte addr[31:4].
   localparam int unsigned BLOCK_OFFSET_W  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } dmem_state_e;

   // Block address as seen by this memory for a 32-bit byte address.
   function automatic logic [BLOCK_ADDR_W-1:0] block_addr(input logic [31:0] byte_addr);
      return byte_addr[31:BLOCK_OFFSET_W];
   endfunction

   // Word sel of a block; word0 occupies the least significant bits.
   function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [1:0]         sel);
      return blk[sel*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/data_memory_if.sv
// Cache <-> main data memory block interface. mem_error is only present
// when DMEM_RANGE_CHECK_EN is defined.
interface data_memory_if;
   import dmem_pkg::*;

   logic                    mem_read;
   logic                    mem_write;
   logic [BLOCK_ADDR_W-1:0] mem_address;
   logic [BLOCK_W-1:0]      mem_WRITE_DATA;
   logic [BLOCK_W-1:0]      mem_READ_DATA;
   logic                    mem_busywait;
`ifdef DMEM_RANGE_CHECK_EN
   logic                    mem_error;

   modport master (
      output mem_read, mem_write, mem_address, mem_WRITE_DATA,
      input  mem_READ_DATA, mem_busywait, mem_error
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_WRITE_DATA,
      output mem_READ_DATA, mem_busywait, mem_error
   );
`else
   modport master (
      output mem_read, mem_write, mem_address, mem_WRITE_DATA,
      input  mem_READ_DATA, mem_busywait
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_WRITE_DATA,
      output mem_READ_DATA, mem_busywait
   );
`endif

endinterface

// File: rtl/dmem_array.sv
// Block storage: synchronous write, registered read. The storage itself is
// never reset; only the read register is.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               we,
   input  logic               re,
   input  logic               rclr,
   input  logic [IDX_W-1:0]   index,
   input  logic [BLOCK_W-1:0] wdata,
   output logic [BLOCK_W-1:0] rdata
);

   logic [BLOCK_W-1:0] mem [DEPTH];

   // Commit a block write.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem[index] <= wdata;
      end
   end

   // Read register holds until the next read; rclr returns zero instead of storage.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= rclr ? '0 : mem[index];
      end
   end

endmodule

// File: rtl/data_memory.sv
// Main data memory: responder end of the data cache's block interface.
// Each access keeps mem_busywait high for exactly LATENCY cycles.
// Optional: DMEM_RANGE_CHECK_EN adds mem_error and rejects addresses >= DEPTH;
// without it, high address bits are ignored and addresses alias modulo DEPTH.
module data_memory
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 5
) (
   input logic          CLK,
   input logic          RESET_N,
   data_memory_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmem_state_e        state;
   logic [CNT_W-1:0]   counter;
   logic               busywait;
   logic               op_write;
   logic [IDX_W-1:0]   index;
   logic [BLOCK_W-1:0] wdata;
   logic [BLOCK_W-1:0] rdata;
   logic               in_range;
   logic               complete;

`ifdef DMEM_RANGE_CHECK_EN
   logic               out_of_range;
   logic               error;

   // Range is judged on the address latched at accept.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         out_of_range <= 1'b0;
         error        <= 1'b0;
      end else begin
         error <= 1'b0;
         if (state == IDLE && (bus.mem_read || bus.mem_write)) begin
            out_of_range <= |bus.mem_address[BLOCK_ADDR_W-1:IDX_W];
         end
         if (complete) begin
            error <= out_of_range;
         end
      end
   end

   assign in_range      = !out_of_range;
   assign bus.mem_error = error;
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.mem_address[BLOCK_ADDR_W-1:IDX_W];
   assign in_range       = 1'b1;
`endif

   assign complete = (state == BUSY) && (counter == '0);

   // Request FSM: accept in IDLE, count down in BUSY, finish when the counter is spent.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         counter  <= '0;
         busywait <= 1'b0;
         op_write <= 1'b0;
         index    <= '0;
         wdata    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.mem_read || bus.mem_write) begin
                  // A simultaneous read and write is treated as a write.
                  op_write <= bus.mem_write;
                  index    <= bus.mem_address[IDX_W-1:0];
                  wdata    <= bus.mem_WRITE_DATA;
                  busywait <= 1'b1;
                  counter  <= CNT_W'(LATENCY - 1);
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (counter != '0) begin
                  counter <= counter - 1'b1;
               end else begin
                  busywait <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .we      (complete && op_write && in_range),
      .re      (complete && !op_write),
      .rclr    (!in_range),
      .index   (index),
      .wdata   (wdata),
      .rdata   (rdata)
   );

   assign bus.mem_busywait  = busywait;
   assign bus.mem_READ_DATA = rdata;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: transaction-level model with per-cycle compare,
// plus directed literal checks.
module tb_data_memory;
   import dmem_pkg::*;

   localparam int unsigned DEPTH   = 256;
   localparam int unsigned LATENCY = 5;
`ifdef DMEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;
   data_memory_if bus ();

   data_memory #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a request seen while idle completes LATENCY cycles later.
   int unsigned  cyc     = 0;
   bit           m_busy  = 1'b0;
   int unsigned  m_done  = 0;
   bit           m_wr    = 1'b0;
   int unsigned  m_idx   = 0;
   bit           m_oor   = 1'b0;
   logic [127:0] m_wdata = '0;
   logic [127:0] mem_m [DEPTH];
   logic [127:0] exp_rdata = '0;
   bit           exp_busy  = 1'b0;
   bit           exp_err   = 1'b0;

   always @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         m_busy    = 1'b0;
         exp_busy  = 1'b0;
         exp_rdata = '0;
         exp_err   = 1'b0;
      end else begin
         cyc++;
         exp_err = 1'b0;
         if (m_busy) begin
            if (cyc == m_done) begin
               if (m_wr) begin
                  if (!m_oor) mem_m[m_idx] = m_wdata;
               end else begin
                  exp_rdata = m_oor ? 128'h0 : mem_m[m_idx];
               end
               m_busy   = 1'b0;
               exp_busy = 1'b0;
               exp_err  = m_oor;
            end
         end else if (bus.mem_read || bus.mem_write) begin
            m_busy   = 1'b1;
            exp_busy = 1'b1;
            m_done   = cyc + LATENCY;
            m_wr     = bus.mem_write;
            m_idx    = int'(bus.mem_address) % DEPTH;
            m_oor    = RC && (int'(bus.mem_address) >= DEPTH);
            m_wdata  = bus.mem_WRITE_DATA;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("busywait", 128'(bus.mem_busywait), 128'(exp_busy));
         check("read_data", bus.mem_READ_DATA, exp_rdata);
`ifdef DMEM_RANGE_CHECK_EN
         check("error", 128'(bus.mem_error), 128'(exp_err));
`endif
      end
   end

   task automatic start(input bit r, input bit w, input logic [27:0] a, input logic [127:0] d);
      bus.mem_read       = r;
      bus.mem_write      = w;
      bus.mem_address    = a;
      bus.mem_WRITE_DATA = d;
   endtask

   task automatic idle();
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   // Count negedges with busywait high until it drops; bounded.
   task automatic wait_done(output int n);
      bit done;
      n    = 0;
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!bus.mem_busywait) begin
            done = 1'b1;
            break;
         end
         n++;
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL busywait_timeout: still high after 100 cycles at %0t", $time);
      end
   endtask

   task automatic access(input bit r, input bit w, input logic [27:0] a, input logic [127:0] d,
                         input string name);
      int n;
      start(r, w, a, d);
      wait_done(n);
      idle();
      check(name, 128'(n), 128'(LATENCY));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] p_blk, q_blk, t2_blk, t3_blk, d1, d2, e_blk;
      int n;
      p_blk  = 128'h55555555_55555555_55555555_55555555;
      q_blk  = 128'h66666666_66666666_66666666_66666666;
      t2_blk = 128'h44444444_33333333_22222222_11111111;
      t3_blk = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
      d1     = 128'h0D1D1D1D_0D1D1D1D_0D1D1D1D_0D1D1D1D;
      d2     = 128'h0D2D2D2D_0D2D2D2D_0D2D2D2D_0D2D2D2D;
      e_blk  = 128'hEEEE0000_EEEE1111_EEEE2222_EEEE3333;

      idle();
      bus.mem_address    = '0;
      bus.mem_WRITE_DATA = '0;
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      chk_en  = 1'b1;
      @(negedge CLK);
      check("reset_busywait", 128'(bus.mem_busywait), 128'h0);
      check("reset_read_data", bus.mem_READ_DATA, 128'h0);

      // Write then read back, LATENCY cycles each.
      access(1'b0, 1'b1, 28'h0000012, t2_blk, "t2_write_latency");
      access(1'b1, 1'b0, 28'h0000012, '0, "t2_read_latency");
      check("t2_read_value", bus.mem_READ_DATA, t2_blk);

      // Reset mid-access aborts the write.
      access(1'b0, 1'b1, 28'h0000040, p_blk, "t1_pre_write_latency");
      start(1'b0, 1'b1, 28'h0000040, q_blk);
      repeat (3) @(negedge CLK);
      #2;
      RESET_N = 1'b0;
      idle();
      #1;
      check("t1_reset_busywait", 128'(bus.mem_busywait), 128'h0);
      check("t1_reset_read_data", bus.mem_READ_DATA, 128'h0);
      @(negedge CLK);
      RESET_N = 1'b1;
      access(1'b1, 1'b0, 28'h0000040, '0, "t1_read_latency");
      check("t1_aborted_write_absent", bus.mem_READ_DATA, p_blk);

      // Write-back then refill with no gap; 0x103 aliases 0x03 without range check.
      start(1'b0, 1'b1, 28'h0000003, t3_blk);
      wait_done(n);
      check("t3_write_latency", 128'(n), 128'(LATENCY));
      start(1'b1, 1'b0, 28'h0000103, '0);
      wait_done(n);
      idle();
      check("t3_refill_latency", 128'(n), 128'(LATENCY));
      if (!RC) check("t3_alias_value", bus.mem_READ_DATA, t3_blk);
      else     check("t3_oor_value", bus.mem_READ_DATA, 128'h0);

      // Read and write together: acts as a write, read data untouched.
      access(1'b1, 1'b1, 28'h0000003, {4{32'hAAAAAAAA}}, "t4_latency");
      check("t4_read_data_held", bus.mem_READ_DATA, RC ? 128'h0 : t3_blk);
      access(1'b1, 1'b0, 28'h0000003, '0, "t4_readback_latency");
      check("t4_readback", bus.mem_READ_DATA, {4{32'hAAAAAAAA}});

      // Inputs changed during BUSY are ignored.
      access(1'b0, 1'b1, 28'h0000021, e_blk, "t5_pre_write_latency");
      start(1'b0, 1'b1, 28'h0000020, d1);
      @(negedge CLK);
      bus.mem_address    = 28'h0000021;
      bus.mem_WRITE_DATA = d2;
      wait_done(n);
      idle();
      check("t5_churn_latency", 128'(n), 128'(LATENCY - 1));
      access(1'b1, 1'b0, 28'h0000020, '0, "t5_read20_latency");
      check("t5_latched_data", bus.mem_READ_DATA, d1);
      access(1'b1, 1'b0, 28'h0000021, '0, "t5_read21_latency");
      check("t5_other_block_intact", bus.mem_READ_DATA, e_blk);

`ifdef DMEM_RANGE_CHECK_EN
      // Out-of-range accesses: zero data, one-cycle error, write dropped.
      access(1'b0, 1'b1, 28'h0000000, p_blk, "t6_write0_latency");
      start(1'b1, 1'b0, 28'h0000100, '0);
      wait_done(n);
      idle();
      check("t6_oor_read_latency", 128'(n), 128'(LATENCY));
      check("t6_oor_read_zero", bus.mem_READ_DATA, 128'h0);
      check("t6_error_pulse", 128'(bus.mem_error), 128'h1);
      @(negedge CLK);
      check("t6_error_cleared", 128'(bus.mem_error), 128'h0);
      access(1'b0, 1'b1, 28'h0000100, q_blk, "t6_oor_write_latency");
      access(1'b1, 1'b0, 28'h0000000, '0, "t6_read0_latency");
      check("t6_block0_unmodified", bus.mem_READ_DATA, p_blk);
`endif

      repeat (2) @(negedge CLK);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
